// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR note scroll / judge datapath.
package ddr_pkg;

    typedef enum logic [1:0] {
        GRADE_NONE    = 2'd0,
        GRADE_MISS    = 2'd1,
        GRADE_GOOD    = 2'd2,
        GRADE_PERFECT = 2'd3
    } grade_t;

    typedef enum logic {
        LANE_IDLE    = 1'b0,
        LANE_FALLING = 1'b1
    } lane_state_t;

    localparam int PTS_PERFECT = 2;
    localparam int PTS_GOOD    = 1;
    localparam int SCORE_W     = 16;
    localparam int COMBO_W     = 8;

endpackage

// File: rtl/note_judge_if.sv
// Bundle between the keypad/tick side (master) and the note judge engine (slave).
// Inputs are level/pulse signals sampled on the rising clock; there is no back-pressure.
interface note_judge_if #(
    parameter int LANES = 4,
    parameter int POS_W = 10
) ();
    import ddr_pkg::*;

    logic                     tick;
    logic [LANES-1:0]         spawn;
    logic [LANES-1:0]         keyValue;
    logic                     keyPressed;
    logic [LANES-1:0]         note_active;
    logic [LANES*POS_W-1:0]   note_pos;
    logic [LANES-1:0]         noteAction;
    logic [2*LANES-1:0]       noteSuccessState;
    logic [SCORE_W-1:0]       score;
    logic [COMBO_W-1:0]       combo;

    modport master (
        output tick, spawn, keyValue, keyPressed,
        input  note_active, note_pos, noteAction, noteSuccessState, score, combo
    );

    modport slave (
        input  tick, spawn, keyValue, keyPressed,
        output note_active, note_pos, noteAction, noteSuccessState, score, combo
    );
endinterface

// File: rtl/note_lane.sv
// One note lane: IDLE/FALLING FSM, position counter and hit-window compare.
// NOTE_JUDGE_EARLY_MISS_EN turns out-of-window presses into MISS and flags idle presses.
module note_lane
    import ddr_pkg::*;
#(
    parameter int POS_W       = 10,
    parameter int HIT_POS     = 400,
    parameter int SPEED       = 1,
    parameter int WIN_PERFECT = 8,
    parameter int WIN_GOOD    = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tick,
    input  logic              i_spawn,
    input  logic              i_key,
    output lane_state_t       o_state,
    output logic [POS_W-1:0]  o_pos,
    output logic              o_action,
    output grade_t            o_grade,
    output logic              o_judge,
    output grade_t            o_judge_grade,
    output logic              o_idle_press
);

    localparam logic signed [POS_W:0] HIT_S    = (POS_W+1)'(HIT_POS);
    localparam logic        [POS_W:0] LIM_PERF = (POS_W+1)'(WIN_PERFECT);
    localparam logic        [POS_W:0] LIM_GOOD = (POS_W+1)'(WIN_GOOD);
    localparam logic        [POS_W:0] LIM_LATE = (POS_W+1)'(HIT_POS + WIN_GOOD);
    localparam logic        [POS_W-1:0] STEP   = POS_W'(SPEED);

    lane_state_t       r_state;
    logic [POS_W-1:0]  r_pos;
    logic              r_action;
    grade_t            r_grade;

    logic signed [POS_W:0] w_diff;
    logic        [POS_W:0] w_abs;
    logic                  w_falling;
    logic                  w_in_perfect;
    logic                  w_in_good;
    logic                  w_hit;
    logic                  w_late;
    logic                  w_early;
    logic                  w_judge;
    grade_t                w_judge_grade;

    // Distance is taken on the pre-tick position, so a same-cycle tick cannot shift the grade.
    assign w_diff       = $signed({1'b0, r_pos}) - HIT_S;
    assign w_abs        = w_diff[POS_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_falling    = (r_state == LANE_FALLING);
    assign w_in_perfect = (w_abs <= LIM_PERF);
    assign w_in_good    = (w_abs <= LIM_GOOD);
    assign w_hit        = w_falling & i_key & w_in_good;
    assign w_late       = w_falling & ({1'b0, r_pos} > LIM_LATE);

`ifdef NOTE_JUDGE_EARLY_MISS_EN
    assign w_early      = w_falling & i_key & ~w_in_good;
    assign o_idle_press = ~w_falling & i_key;
`else
    assign w_early      = 1'b0;
    assign o_idle_press = 1'b0;
`endif

    assign w_judge       = w_hit | w_late | w_early;
    assign w_judge_grade = w_hit ? (w_in_perfect ? GRADE_PERFECT : GRADE_GOOD) : GRADE_MISS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LANE_IDLE;
            r_pos    <= '0;
            r_action <= 1'b0;
            r_grade  <= GRADE_NONE;
        end else begin
            r_action <= 1'b0;
            case (r_state)
                LANE_IDLE: begin
                    if (i_spawn) begin
                        r_state <= LANE_FALLING;
                        r_pos   <= '0;
                    end
                end
                LANE_FALLING: begin
                    // A judgement wins over both a tick and a spawn in the same cycle.
                    if (w_judge) begin
                        r_state  <= LANE_IDLE;
                        r_pos    <= '0;
                        r_action <= 1'b1;
                        r_grade  <= w_judge_grade;
                    end else if (i_tick) begin
                        r_pos <= r_pos + STEP;
                    end
                end
                default: r_state <= LANE_IDLE;
            endcase
        end
    end

    assign o_state       = r_state;
    assign o_pos         = r_pos;
    assign o_action      = r_action;
    assign o_grade       = r_grade;
    assign o_judge       = w_judge;
    assign o_judge_grade = w_judge_grade;

endmodule

// File: rtl/note_judge.sv
// Multi-lane note scroll and hit judge: LANES note_lane instances plus saturating score/combo.
// Optional NOTE_JUDGE_EARLY_MISS_EN (handled in note_lane) also lets idle presses clear combo.
module note_judge
    import ddr_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int POS_W       = 10,
    parameter int HIT_POS     = 400,
    parameter int SPEED       = 1,
    parameter int WIN_PERFECT = 8,
    parameter int WIN_GOOD    = 24
) (
    input  logic        clk,
    input  logic        rst,
    note_judge_if.slave bus
);

    localparam logic [SCORE_W:0] SCORE_MAX = (SCORE_W+1)'({SCORE_W{1'b1}});
    localparam logic [SCORE_W:0] COMBO_MAX = (SCORE_W+1)'({COMBO_W{1'b1}});

    lane_state_t       w_state       [LANES];
    logic [POS_W-1:0]  w_pos         [LANES];
    grade_t            w_grade       [LANES];
    grade_t            w_judge_grade [LANES];
    logic [LANES-1:0]  w_action;
    logic [LANES-1:0]  w_judge;
    logic [LANES-1:0]  w_idle_press;

    logic [SCORE_W:0]  w_pts;
    logic [SCORE_W:0]  w_hits;
    logic              w_clear;
    logic [SCORE_W:0]  w_score_sum;
    logic [SCORE_W:0]  w_combo_sum;

    logic [SCORE_W-1:0] r_score;
    logic [COMBO_W-1:0] r_combo;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        note_lane #(
            .POS_W       (POS_W),
            .HIT_POS     (HIT_POS),
            .SPEED       (SPEED),
            .WIN_PERFECT (WIN_PERFECT),
            .WIN_GOOD    (WIN_GOOD)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst),
            .i_tick        (bus.tick),
            .i_spawn       (bus.spawn[g]),
            .i_key         (bus.keyPressed & bus.keyValue[g]),
            .o_state       (w_state[g]),
            .o_pos         (w_pos[g]),
            .o_action      (w_action[g]),
            .o_grade       (w_grade[g]),
            .o_judge       (w_judge[g]),
            .o_judge_grade (w_judge_grade[g]),
            .o_idle_press  (w_idle_press[g])
        );

        assign bus.note_active[g]            = (w_state[g] == LANE_FALLING);
        assign bus.note_pos[g*POS_W +: POS_W] = w_pos[g];
        assign bus.noteSuccessState[2*g +: 2] = w_grade[g];
    end

    assign bus.noteAction = w_action;

    // Points and hit count summed over every lane judged in this cycle.
    always_comb begin
        w_pts   = '0;
        w_hits  = '0;
        w_clear = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (w_judge[i]) begin
                case (w_judge_grade[i])
                    GRADE_PERFECT: begin
                        w_pts  = w_pts + (SCORE_W+1)'(PTS_PERFECT);
                        w_hits = w_hits + 1'b1;
                    end
                    GRADE_GOOD: begin
                        w_pts  = w_pts + (SCORE_W+1)'(PTS_GOOD);
                        w_hits = w_hits + 1'b1;
                    end
                    default: w_clear = 1'b1;
                endcase
            end
            if (w_idle_press[i]) begin
                w_clear = 1'b1;
            end
        end
    end

    assign w_score_sum = {1'b0, r_score} + w_pts;
    assign w_combo_sum = (SCORE_W+1)'(r_combo) + w_hits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_score <= '0;
            r_combo <= '0;
        end else begin
            r_score <= (w_score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : w_score_sum[SCORE_W-1:0];
            if (w_clear) begin
                r_combo <= '0;
            end else begin
                r_combo <= (w_combo_sum > COMBO_MAX) ? COMBO_MAX[COMBO_W-1:0] : w_combo_sum[COMBO_W-1:0];
            end
        end
    end

    assign bus.score = r_score;
    assign bus.combo = r_combo;

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge: judgements are queued as expected and checked by a monitor.
module tb_note_judge;
    import ddr_pkg::*;

    localparam int LANES = 4;
    localparam int POS_W = 10;
    localparam int EW    = LANES + 2*LANES + SCORE_W + COMBO_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    note_judge_if #(.LANES(LANES), .POS_W(POS_W)) bus ();

    note_judge #(
        .LANES(LANES), .POS_W(POS_W), .HIT_POS(400), .SPEED(1),
        .WIN_PERFECT(8), .WIN_GOOD(24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0]        exp_q[$];
    logic [2*LANES-1:0]   exp_grades = '0;
    int                   exp_score  = 0;
    int                   exp_combo  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_spawn(input logic [LANES-1:0] m);
        bus.spawn = m;
        cycle();
        bus.spawn = '0;
    endtask

    task automatic do_ticks(input int n);
        bus.tick = 1'b1;
        repeat (n) cycle();
        bus.tick = 1'b0;
    endtask

    task automatic do_press(input logic [LANES-1:0] m, input logic qual);
        bus.keyValue   = m;
        bus.keyPressed = qual;
        cycle();
        bus.keyPressed = 1'b0;
        bus.keyValue   = '0;
    endtask

    // Every lane in m gets grade g in the same cycle.
    task automatic expect_judge(input logic [LANES-1:0] m, input grade_t g);
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) begin
                exp_grades[2*i +: 2] = g;
                if (g == GRADE_PERFECT) exp_score += 2;
                if (g == GRADE_GOOD)    exp_score += 1;
                if (g == GRADE_MISS) exp_combo = 0;
                else                 exp_combo = (exp_combo >= 255) ? 255 : exp_combo + 1;
            end
        end
        if (exp_score > 16'hFFFF) exp_score = 16'hFFFF;
        exp_q.push_back({m, exp_grades, 16'(exp_score), 8'(exp_combo)});
    endtask

    function automatic logic [POS_W-1:0] lane_pos(input int i);
        return bus.note_pos[i*POS_W +: POS_W];
    endfunction

    // Monitor: any noteAction must match the oldest queued judgement.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst && bus.noteAction !== '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_action: got %b expected none", bus.noteAction);
            end else begin
                e = exp_q.pop_front();
                check("action", 64'(bus.noteAction),       64'(e[EW-1 -: LANES]));
                check("grades", 64'(bus.noteSuccessState), 64'(e[SCORE_W+COMBO_W +: 2*LANES]));
                check("score",  64'(bus.score),            64'(e[COMBO_W +: SCORE_W]));
                check("combo",  64'(bus.combo),            64'(e[COMBO_W-1:0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick = 1'b0; bus.spawn = '0; bus.keyValue = '0; bus.keyPressed = 1'b0;
        repeat (3) cycle();
        check("rst_active", 64'(bus.note_active), 64'h0);
        check("rst_score",  64'(bus.score),       64'h0);
        check("rst_grades", 64'(bus.noteSuccessState), 64'h0);
        rst = 1'b1;
        cycle();
        check("idle_active", 64'(bus.note_active), 64'h0);
        check("idle_combo",  64'(bus.combo),       64'h0);

        // Asynchronous reset mid-fall discards the note silently.
        do_spawn(4'b0001);
        do_ticks(200);
        check("fall_pos200", 64'(lane_pos(0)), 64'd200);
        check("fall_active", 64'(bus.note_active), 64'h1);
        #2 rst = 1'b0;
        #1;
        check("async_active", 64'(bus.note_active), 64'h0);
        check("async_pos",    64'(bus.note_pos),    64'h0);
        check("async_action", 64'(bus.noteAction),  64'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        cycle();
        do_ticks(10);
        check("post_rst_idle", 64'(bus.note_active), 64'h0);

        // PERFECT on lane 2 at exactly the target line.
        do_spawn(4'b0100);
        do_ticks(400);
        check("l2_pos400", 64'(lane_pos(2)), 64'd400);
        expect_judge(4'b0100, GRADE_PERFECT);
        do_press(4'b0100, 1'b1);
        cycle();
        check("l2_cleared", 64'(bus.note_active), 64'h0);
        check("l2_pos0",    64'(lane_pos(2)),     64'd0);

        // GOOD on lane 0 at 380, then lane 1 falls to 425 and misses.
        do_spawn(4'b0011);
        do_ticks(380);
        expect_judge(4'b0001, GRADE_GOOD);
        do_press(4'b0001, 1'b1);
        expect_judge(4'b0010, GRADE_MISS);
        do_ticks(45);
        check("l1_pos425", 64'(lane_pos(1)), 64'd425);
        check("l1_not_yet", 64'(bus.noteAction), 64'h0);
        cycle();
        cycle();
        check("l1_idle", 64'(bus.note_active), 64'h0);

        // Two lanes judged in one strobe.
        do_spawn(4'b1001);
        do_ticks(400);
        expect_judge(4'b1001, GRADE_PERFECT);
        do_press(4'b1001, 1'b1);
        cycle();

        // Out-of-window press on lane 1 at pos 300.
        do_spawn(4'b0010);
        do_ticks(300);
`ifdef NOTE_JUDGE_EARLY_MISS_EN
        expect_judge(4'b0010, GRADE_MISS);
        do_press(4'b0010, 1'b1);
        cycle();
        check("early_miss_idle", 64'(bus.note_active), 64'h0);
`else
        do_press(4'b0010, 1'b1);
        check("ignored_active", 64'(bus.note_active), 64'h2);
        check("ignored_pos300", 64'(lane_pos(1)),     64'd300);
        do_ticks(100);
        expect_judge(4'b0010, GRADE_PERFECT);
        do_press(4'b0010, 1'b1);
        cycle();
`endif

        // Press on an idle lane.
        do_press(4'b0001, 1'b1);
`ifdef NOTE_JUDGE_EARLY_MISS_EN
        exp_combo = 0;
`endif
        cycle();
        check("idle_press_combo", 64'(bus.combo), 64'(exp_combo));

        // Spawn on a falling lane and an unqualified key are both ignored.
        do_spawn(4'b1000);
        do_ticks(50);
        do_spawn(4'b1000);
        check("respawn_pos50", 64'(lane_pos(3)), 64'd50);
        do_ticks(350);
        do_press(4'b1000, 1'b0);
        check("unqual_active", 64'(bus.note_active), 64'h8);
        expect_judge(4'b1000, GRADE_PERFECT);
        do_press(4'b1000, 1'b1);
        cycle();

        // Drive combo to saturation, then one more PERFECT.
        for (int r = 0; r < 64; r++) begin
            do_spawn(4'b1111);
            do_ticks(400);
            expect_judge(4'b1111, GRADE_PERFECT);
            do_press(4'b1111, 1'b1);
        end
        cycle();
        check("combo_sat", 64'(bus.combo), 64'd255);
        do_spawn(4'b0100);
        do_ticks(400);
        expect_judge(4'b0100, GRADE_PERFECT);
        do_press(4'b0100, 1'b1);
        cycle();
        check("combo_stays", 64'(bus.combo), 64'd255);
        check("score_final", 64'(bus.score), 64'(exp_score));

        repeat (3) cycle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
